// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit pipeline: widths, ALU op codes and branch type codes.
package pipe_pkg;

  localparam int DATA_W = 8;
  localparam int PC_W   = 12;
  localparam int RA_W   = 3;

  // Bit of aluOp that replaces the forwarded rt operand with immConst
  localparam int ALU_IMM = 3;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_ADC  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_SBC  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_MASK = 3'b111
  } aluOp_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_Z    = 2'b01,
    BR_C    = 2'b10,
    BR_JMP  = 2'b11
  } brType_e;

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU: arithmetic in DATA_W+1 bits so the top bit is the carry out.
module exe_alu
  import pipe_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  input  aluOp_e            op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] aExt;
  logic [DATA_W:0] bExt;
  logic [DATA_W:0] bInvExt;
  logic [DATA_W:0] cinExt;
  logic [DATA_W:0] sum;

  assign aExt    = {1'b0, a_i};
  assign bExt    = {1'b0, b_i};
  assign bInvExt = {1'b0, ~b_i};
  assign cinExt  = {{DATA_W{1'b0}}, cin_i};

  // Subtraction carry is the inverted borrow: 1 means no borrow occurred
  always_comb begin
    sum = '0;
    case (op_i)
      ALU_ADD:  sum = aExt + bExt;
      ALU_ADC:  sum = aExt + bExt + cinExt;
      ALU_SUB:  sum = aExt + bInvExt + {{DATA_W{1'b0}}, 1'b1};
      ALU_SBC:  sum = aExt + bInvExt + cinExt;
      ALU_AND:  sum = {1'b0, a_i & b_i};
      ALU_OR:   sum = {1'b0, a_i | b_i};
      ALU_XOR:  sum = {1'b0, a_i ^ b_i};
      ALU_MASK: sum = {1'b0, a_i & ~b_i};
      default:  sum = '0;
    endcase
  end

  assign result_o = sum[DATA_W-1:0];
  assign carry_o  = sum[DATA_W];
  assign zero_o   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, C/Z flag registers, branch resolution and
// the EXE/MEM pipeline register.
module exe_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              regWr_IN,
  input  logic              memRd_IN,
  input  logic              memWr_IN,
  input  logic              cWr_IN,
  input  logic              zWr_IN,
  input  logic [3:0]        aluOp_IN,
  input  logic [1:0]        brType_IN,
  input  logic [RA_W-1:0]   rd_IN,
  input  logic [RA_W-1:0]   rs_IN,
  input  logic [RA_W-1:0]   rt_IN,
  input  logic [DATA_W-1:0] regData1_IN,
  input  logic [DATA_W-1:0] regData2_IN,
  input  logic [DATA_W-1:0] immConst_IN,
  input  logic [DATA_W-1:0] brDisp_IN,
  input  logic [PC_W-1:0]   pcPlus1_IN,
  input  logic              memRegWr_IN,
  input  logic [RA_W-1:0]   memRd_addr_IN,
  input  logic [DATA_W-1:0] memVal_IN,
  input  logic              wbRegWr_IN,
  input  logic [RA_W-1:0]   wbRd_IN,
  input  logic [DATA_W-1:0] wbVal_IN,
  output logic              brTaken_OUT,
  output logic [PC_W-1:0]   brTarget_OUT,
  output logic              flush_OUT,
  output logic              regWr_OUT,
  output logic              memRd_OUT,
  output logic              memWr_OUT,
  output logic [RA_W-1:0]   rd_OUT,
  output logic [DATA_W-1:0] aluRes_OUT,
  output logic [DATA_W-1:0] stData_OUT,
  output logic              cFlag_OUT,
  output logic              zFlag_OUT
);

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluRes;
  logic              aluCarry;
  logic              aluZero;
  logic              brCond;

  logic              regWr_q, regWr_d;
  logic              memRd_q, memRd_d;
  logic              memWr_q, memWr_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] aluRes_q, aluRes_d;
  logic [DATA_W-1:0] stData_q, stData_d;
  logic              cFlag_q, cFlag_d;
  logic              zFlag_q, zFlag_d;

  // The younger producer (MEM) wins over WB when both target the same register
  always_comb begin
    opA = regData1_IN;
    if (memRegWr_IN && (memRd_addr_IN == rs_IN))
      opA = memVal_IN;
    else if (wbRegWr_IN && (wbRd_IN == rs_IN))
      opA = wbVal_IN;

    fwdB = regData2_IN;
    if (memRegWr_IN && (memRd_addr_IN == rt_IN))
      fwdB = memVal_IN;
    else if (wbRegWr_IN && (wbRd_IN == rt_IN))
      fwdB = wbVal_IN;
  end

  assign opB = aluOp_IN[ALU_IMM] ? immConst_IN : fwdB;

  exe_alu uAlu (
    .a_i      (opA),
    .b_i      (opB),
    .cin_i    (cFlag_q),
    .op_i     (aluOp_e'(aluOp_IN[2:0])),
    .result_o (aluRes),
    .carry_o  (aluCarry),
    .zero_o   (aluZero)
  );

  // Branches look at the flag registers as they stand before this cycle's update
  always_comb begin
    brCond = 1'b0;
    case (brType_e'(brType_IN))
      BR_NONE: brCond = 1'b0;
      BR_Z:    brCond = zFlag_q;
      BR_C:    brCond = cFlag_q;
      BR_JMP:  brCond = 1'b1;
      default: brCond = 1'b0;
    endcase
  end

  assign brTaken_OUT  = brCond & ~rst;
  assign flush_OUT    = brTaken_OUT;
  assign brTarget_OUT = pcPlus1_IN + {{(PC_W-DATA_W){brDisp_IN[DATA_W-1]}}, brDisp_IN};

  always_comb begin
    regWr_d  = regWr_IN;
    memRd_d  = memRd_IN;
    memWr_d  = memWr_IN;
    rd_d     = rd_IN;
    aluRes_d = aluRes;
    stData_d = fwdB;
    cFlag_d  = cWr_IN ? aluCarry : cFlag_q;
    zFlag_d  = zWr_IN ? aluZero  : zFlag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWr_q  <= 1'b0;
      memRd_q  <= 1'b0;
      memWr_q  <= 1'b0;
      rd_q     <= '0;
      aluRes_q <= '0;
      stData_q <= '0;
      cFlag_q  <= 1'b0;
      zFlag_q  <= 1'b0;
    end else begin
      regWr_q  <= regWr_d;
      memRd_q  <= memRd_d;
      memWr_q  <= memWr_d;
      rd_q     <= rd_d;
      aluRes_q <= aluRes_d;
      stData_q <= stData_d;
      cFlag_q  <= cFlag_d;
      zFlag_q  <= zFlag_d;
    end
  end

  assign regWr_OUT  = regWr_q;
  assign memRd_OUT  = memRd_q;
  assign memWr_OUT  = memWr_q;
  assign rd_OUT     = rd_q;
  assign aluRes_OUT = aluRes_q;
  assign stData_OUT = stData_q;
  assign cFlag_OUT  = cFlag_q;
  assign zFlag_OUT  = zFlag_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a small behavioural model predicts each instruction's
// branch outputs immediately and its EXE/MEM results one edge later.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN;
  logic [3:0]  aluOp_IN;
  logic [1:0]  brType_IN;
  logic [2:0]  rd_IN, rs_IN, rt_IN;
  logic [7:0]  regData1_IN, regData2_IN, immConst_IN, brDisp_IN;
  logic [11:0] pcPlus1_IN;
  logic        memRegWr_IN;
  logic [2:0]  memRd_addr_IN;
  logic [7:0]  memVal_IN;
  logic        wbRegWr_IN;
  logic [2:0]  wbRd_IN;
  logic [7:0]  wbVal_IN;
  logic        brTaken_OUT;
  logic [11:0] brTarget_OUT;
  logic        flush_OUT;
  logic        regWr_OUT, memRd_OUT, memWr_OUT;
  logic [2:0]  rd_OUT;
  logic [7:0]  aluRes_OUT, stData_OUT;
  logic        cFlag_OUT, zFlag_OUT;

  typedef struct {
    string tag;
    int    aluRes;
    int    stData;
    int    rd;
    int    regWr;
    int    memRd;
    int    memWr;
    int    cFlag;
    int    zFlag;
  } expect_t;

  expect_t scoreboard[$];

  int assertCount;
  int failCount;
  int modelC;
  int modelZ;

  exe_stage dut (
    .clk           (clk),
    .rst           (rst),
    .regWr_IN      (regWr_IN),
    .memRd_IN      (memRd_IN),
    .memWr_IN      (memWr_IN),
    .cWr_IN        (cWr_IN),
    .zWr_IN        (zWr_IN),
    .aluOp_IN      (aluOp_IN),
    .brType_IN     (brType_IN),
    .rd_IN         (rd_IN),
    .rs_IN         (rs_IN),
    .rt_IN         (rt_IN),
    .regData1_IN   (regData1_IN),
    .regData2_IN   (regData2_IN),
    .immConst_IN   (immConst_IN),
    .brDisp_IN     (brDisp_IN),
    .pcPlus1_IN    (pcPlus1_IN),
    .memRegWr_IN   (memRegWr_IN),
    .memRd_addr_IN (memRd_addr_IN),
    .memVal_IN     (memVal_IN),
    .wbRegWr_IN    (wbRegWr_IN),
    .wbRd_IN       (wbRd_IN),
    .wbVal_IN      (wbVal_IN),
    .brTaken_OUT   (brTaken_OUT),
    .brTarget_OUT  (brTarget_OUT),
    .flush_OUT     (flush_OUT),
    .regWr_OUT     (regWr_OUT),
    .memRd_OUT     (memRd_OUT),
    .memWr_OUT     (memWr_OUT),
    .rd_OUT        (rd_OUT),
    .aluRes_OUT    (aluRes_OUT),
    .stData_OUT    (stData_OUT),
    .cFlag_OUT     (cFlag_OUT),
    .zFlag_OUT     (zFlag_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Integer-arithmetic reference: ~b over 8 bits is written as 255-b
  function automatic void modelAlu(input int op, input int a, input int b, input int cin,
                                   output int res, output int cy);
    int t;
    case (op)
      0:       t = a + b;
      1:       t = a + b + cin;
      2:       t = a + 256 - b;
      3:       t = a + (255 - b) + cin;
      4:       t = a & b;
      5:       t = a | b;
      6:       t = a ^ b;
      default: t = a & (255 - b);
    endcase
    res = t % 256;
    cy  = (t >= 256) ? 1 : 0;
  endfunction

  function automatic int modelFwd(input int addr, input int regVal);
    if (memRegWr_IN && (int'(memRd_addr_IN) == addr)) return int'(memVal_IN);
    if (wbRegWr_IN && (int'(wbRd_IN) == addr)) return int'(wbVal_IN);
    return regVal;
  endfunction

  task automatic setBubble();
    {regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN} = '0;
    aluOp_IN = '0; brType_IN = '0;
    rd_IN = '0; rs_IN = '0; rt_IN = '0;
    regData1_IN = '0; regData2_IN = '0; immConst_IN = '0; brDisp_IN = '0;
    pcPlus1_IN = '0;
    memRegWr_IN = 1'b0; memRd_addr_IN = '0; memVal_IN = '0;
    wbRegWr_IN = 1'b0; wbRd_IN = '0; wbVal_IN = '0;
  endtask

  // Inputs are expected to be set just after a falling edge; this checks the
  // combinational branch outputs, queues the registered prediction and retires it after the edge.
  task automatic applyStimulus(input string tag);
    int a, bFwd, b, res, cy, taken, disp, target;
    expect_t e;
    #1;
    a    = modelFwd(int'(rs_IN), int'(regData1_IN));
    bFwd = modelFwd(int'(rt_IN), int'(regData2_IN));
    b    = aluOp_IN[3] ? int'(immConst_IN) : bFwd;
    modelAlu(int'(aluOp_IN[2:0]), a, b, modelC, res, cy);
    case (brType_IN)
      2'b01:   taken = modelZ;
      2'b10:   taken = modelC;
      2'b11:   taken = 1;
      default: taken = 0;
    endcase
    disp   = (brDisp_IN >= 8'h80) ? int'(brDisp_IN) - 256 : int'(brDisp_IN);
    target = (int'(pcPlus1_IN) + disp + 4096) % 4096;
    checkOutput({tag, ".brTaken"}, int'(brTaken_OUT), taken);
    checkOutput({tag, ".flush"}, int'(flush_OUT), taken);
    if (brType_IN != 2'b00)
      checkOutput({tag, ".brTarget"}, int'(brTarget_OUT), target);
    if (cWr_IN) modelC = cy;
    if (zWr_IN) modelZ = (res == 0) ? 1 : 0;
    e.tag = tag; e.aluRes = res; e.stData = bFwd; e.rd = int'(rd_IN);
    e.regWr = int'(regWr_IN); e.memRd = int'(memRd_IN); e.memWr = int'(memWr_IN);
    e.cFlag = modelC; e.zFlag = modelZ;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, ".scoreboardEmpty"}, 0, 1);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({e.tag, ".aluRes"}, int'(aluRes_OUT), e.aluRes);
      checkOutput({e.tag, ".stData"}, int'(stData_OUT), e.stData);
      checkOutput({e.tag, ".rd"}, int'(rd_OUT), e.rd);
      checkOutput({e.tag, ".regWr"}, int'(regWr_OUT), e.regWr);
      checkOutput({e.tag, ".memRd"}, int'(memRd_OUT), e.memRd);
      checkOutput({e.tag, ".memWr"}, int'(memWr_OUT), e.memWr);
      checkOutput({e.tag, ".cFlag"}, int'(cFlag_OUT), e.cFlag);
      checkOutput({e.tag, ".zFlag"}, int'(zFlag_OUT), e.zFlag);
    end
  endtask

  task automatic aluOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cw, input logic zw, input string tag);
    @(negedge clk);
    setBubble();
    regWr_IN = 1'b1; rd_IN = 3'd1; rs_IN = 3'd4; rt_IN = 3'd5;
    aluOp_IN = op; regData1_IN = a; regData2_IN = b; immConst_IN = b;
    cWr_IN = cw; zWr_IN = zw;
    applyStimulus(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".regWr"}, int'(regWr_OUT), 0);
    checkOutput({tag, ".memRd"}, int'(memRd_OUT), 0);
    checkOutput({tag, ".memWr"}, int'(memWr_OUT), 0);
    checkOutput({tag, ".rd"}, int'(rd_OUT), 0);
    checkOutput({tag, ".aluRes"}, int'(aluRes_OUT), 0);
    checkOutput({tag, ".stData"}, int'(stData_OUT), 0);
    checkOutput({tag, ".cFlag"}, int'(cFlag_OUT), 0);
    checkOutput({tag, ".zFlag"}, int'(zFlag_OUT), 0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    modelC      = 0;
    modelZ      = 0;
    rst = 1'b1;
    setBubble();
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    aluOp(4'b0000, 8'hF0, 8'h20, 1'b1, 1'b1, "add");
    checkOutput("addConst.res", int'(aluRes_OUT), 8'h10);
    checkOutput("addConst.c", int'(cFlag_OUT), 1);
    aluOp(4'b0001, 8'h01, 8'h01, 1'b1, 1'b1, "adc");
    checkOutput("adcConst.res", int'(aluRes_OUT), 8'h03);
    aluOp(4'b0010, 8'h05, 8'h05, 1'b1, 1'b1, "sub");
    checkOutput("subConst.z", int'(zFlag_OUT), 1);

    @(negedge clk);
    setBubble();
    brType_IN = 2'b01; pcPlus1_IN = 12'h0FE; brDisp_IN = 8'h80;
    #1;
    checkOutput("bzConst.target", int'(brTarget_OUT), 12'h07E);
    applyStimulus("bzTaken");

    aluOp(4'b0100, 8'h0F, 8'hF0, 1'b1, 1'b0, "andClrC");
    aluOp(4'b0011, 8'h00, 8'h01, 1'b1, 1'b1, "sbc");
    checkOutput("sbcConst.res", int'(aluRes_OUT), 8'hFE);
    checkOutput("sbcConst.c", int'(cFlag_OUT), 0);

    @(negedge clk);
    setBubble();
    brType_IN = 2'b01; pcPlus1_IN = 12'h0FE; brDisp_IN = 8'h80;
    #1;
    checkOutput("bzConst.notTaken", int'(brTaken_OUT), 0);
    applyStimulus("bzNotTaken");

    @(negedge clk);
    setBubble();
    regWr_IN = 1'b1; rd_IN = 3'd2; rs_IN = 3'd3; rt_IN = 3'd3; aluOp_IN = 4'b1000;
    regData1_IN = 8'h55; regData2_IN = 8'h66;
    memRegWr_IN = 1'b1; memRd_addr_IN = 3'd3; memVal_IN = 8'h11;
    wbRegWr_IN = 1'b1; wbRd_IN = 3'd3; wbVal_IN = 8'h22;
    applyStimulus("fwdMem");
    checkOutput("fwdMemConst.res", int'(aluRes_OUT), 8'h11);

    @(negedge clk);
    memRegWr_IN = 1'b0;
    applyStimulus("fwdWb");
    checkOutput("fwdWbConst.res", int'(aluRes_OUT), 8'h22);

    @(negedge clk);
    setBubble();
    brType_IN = 2'b11; pcPlus1_IN = 12'hFFF; brDisp_IN = 8'h01;
    #1;
    checkOutput("jmpConst.target", int'(brTarget_OUT), 12'h000);
    applyStimulus("jmpWrap");

    @(negedge clk);
    setBubble();
    regWr_IN = 1'b1; memWr_IN = 1'b1; rd_IN = 3'd6; rs_IN = 3'd1; rt_IN = 3'd2;
    aluOp_IN = 4'b1000; regData1_IN = 8'h10; regData2_IN = 8'h77; immConst_IN = 8'h05;
    applyStimulus("addi");
    checkOutput("addiConst.res", int'(aluRes_OUT), 8'h15);
    checkOutput("addiConst.st", int'(stData_OUT), 8'h77);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      {regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN} = 5'($urandom_range(0, 31));
      aluOp_IN      = 4'($urandom_range(0, 15));
      brType_IN     = 2'($urandom_range(0, 3));
      rd_IN         = 3'($urandom_range(0, 7));
      rs_IN         = 3'($urandom_range(0, 7));
      rt_IN         = 3'($urandom_range(0, 7));
      regData1_IN   = 8'($urandom_range(0, 255));
      regData2_IN   = 8'($urandom_range(0, 255));
      immConst_IN   = 8'($urandom_range(0, 255));
      brDisp_IN     = 8'($urandom_range(0, 255));
      pcPlus1_IN    = 12'($urandom_range(0, 4095));
      memRegWr_IN   = 1'($urandom_range(0, 1));
      memRd_addr_IN = 3'($urandom_range(0, 7));
      memVal_IN     = 8'($urandom_range(0, 255));
      wbRegWr_IN    = 1'($urandom_range(0, 1));
      wbRd_IN       = 3'($urandom_range(0, 7));
      wbVal_IN      = 8'($urandom_range(0, 255));
      applyStimulus($sformatf("rand%0d", i));
    end

    aluOp(4'b0000, 8'hFF, 8'h01, 1'b1, 1'b0, "preReset");
    @(negedge clk);
    setBubble();
    brType_IN = 2'b11;
    rst = 1'b1;
    #1;
    checkAllZero("midReset");
    checkOutput("midReset.brTaken", int'(brTaken_OUT), 0);
    checkOutput("midReset.flush", int'(flush_OUT), 0);
    modelC = 0;
    modelZ = 0;
    scoreboard.delete();
    @(negedge clk);
    rst = 1'b0;
    aluOp(4'b0110, 8'hA5, 8'hA5, 1'b1, 1'b1, "postReset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
